// File: rtl/cpu_defs.sv
// Shared definitions for the 16-bit CPU front end: opcode values and the
// fetch/decode FSM state encoding.
package cpu_defs;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of an instruction word into its fields plus the
// immediate classification that steers the sign extender.
module instr_field_decode
  import cpu_defs::*;
(
  input  logic [15:0] ir_i,
  output logic [3:0]  opcode_o,
  output logic [3:0]  rdest_o,
  output logic [3:0]  opext_o,
  output logic [3:0]  rsrc_o,
  output logic [7:0]  imm8_o,
  output logic        imm_signed_o,
  output logic        is_imm_o
);

  assign opcode_o = ir_i[15:12];
  assign rdest_o  = ir_i[11:8];
  assign opext_o  = ir_i[7:4];
  assign rsrc_o   = ir_i[3:0];
  assign imm8_o   = ir_i[7:0];

  always_comb begin
    is_imm_o     = 1'b0;
    imm_signed_o = 1'b0;
    case (ir_i[15:12])
      OP_ADDI, OP_SUBI, OP_CMPI, OP_BCOND: begin
        is_imm_o     = 1'b1;
        imm_signed_o = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_MOVI, OP_LUI: begin
        is_imm_o = 1'b1;
      end
      // shifts take a shift-amount immediate only when opext[0] is set
      OP_SHIFT: is_imm_o = ir_i[4];
      default: begin
        is_imm_o     = 1'b0;
        imm_signed_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_fetch.sv
// Fetch/decode stage: owns the PC and IR, fetches from 1-cycle-latency
// instruction memory and presents decoded fields under a valid/ready handshake.
module instr_decode_fetch
  import cpu_defs::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] pc_out,
  output logic [3:0]  opcode,
  output logic [3:0]  rdest,
  output logic [3:0]  opext,
  output logic [3:0]  rsrc,
  output logic [7:0]  imm8,
  output logic        imm_signed,
  output logic        is_imm
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        ir_d    = imem_rdata;
        state_d = S_VALID;
      end
      S_VALID: begin
        if (dec_ready) begin
          pc_d    = pc_q + 16'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
    // a redirect overrides everything, including an in-flight read or acceptance
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      ir_d    = ir_q;
      state_d = S_FETCH;
    end
  end

  always_comb begin
    imem_rd   = (state_q == S_FETCH);
    dec_valid = (state_q == S_VALID);
    imem_addr = pc_q;
    pc_out    = pc_q;
  end

  instr_field_decode u_field_decode (
    .ir_i         (ir_q),
    .opcode_o     (opcode),
    .rdest_o      (rdest),
    .opext_o      (opext),
    .rsrc_o       (rsrc),
    .imm8_o       (imm8),
    .imm_signed_o (imm_signed),
    .is_imm_o     (is_imm)
  );

endmodule

// File: doc/instr_decode_fetch.md
# instr_decode_fetch

Instruction fetch and decode stage of the 16-bit CPU. It owns the PC, reads instruction words from synchronous instruction memory, holds them in an instruction register, and splits each word into register, opcode and immediate fields. Its `imm8`/`imm_signed` outputs feed the sign extender directly. A valid/ready handshake to the execute controller stalls it.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `imem_addr`  out  16: instruction memory word address.
- `imem_rd`  out  1: read strobe. High only in FETCH.
- `imem_rdata`  in  16: read data. Valid in the cycle after `imem_rd` (fixed 1-cycle latency).
- `redirect_valid`  in  1: branch/jump taken, 1-cycle pulse.
- `redirect_pc`  in  16: target address.
- `dec_valid`  out  1: decoded fields are valid.
- `dec_ready`  in  1: execute stage accepts the decoded instruction.
- `pc_out`  out  16: address of the decoded instruction.
- `opcode`  out  4: IR[15:12].
- `rdest`  out  4: IR[11:8].
- `opext`  out  4: IR[7:4].
- `rsrc`  out  4: IR[3:0].
- `imm8`  out  8: IR[7:0], to the sign extender `In`.
- `imm_signed`  out  1: to the sign extender `S`.
- `is_imm`  out  1: instruction uses an immediate operand.

## Operation
- FSM states and transitions:
  - FETCH: drive `imem_addr=pc`, `imem_rd=1`. Next state is WAIT.
  - WAIT: load IR ← `imem_rdata`. Next state is VALID.
  - VALID: `dec_valid=1`. If `dec_ready`: pc ← pc+1 and go to FETCH. Otherwise stay in VALID.
- Decoded outputs are combinational from IR and stay stable while in VALID.
- Immediate classes (opcodes):
  - Signed: ADDI 0101, SUBI 1001, CMPI 1011, Bcond 1100. `is_imm=1`, `imm_signed=1`.
  - Unsigned: ANDI 0001, ORI 0010, XORI 0011, MOVI 1101, LUI 1111. `is_imm=1`, `imm_signed=0`.
  - Shift opcode 1000: `is_imm=opext[0]`, `imm_signed=0`.
  - Opcode 0000 (register type) and all others: `is_imm=0`, `imm_signed=0`.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000.
- Redirect in any state: pc ← `redirect_pc`, next state FETCH. An in-flight read is discarded and IR is not loaded.
- Redirect in VALID with `dec_ready=1` in the same cycle: the instruction counts as consumed and the redirect wins (pc ← `redirect_pc`, not pc+1).
- Reset mid-fetch: returns immediately to FETCH state values. Stale `imem_rdata` is ignored.

## Timing
- Reset values:
  - State FETCH, pc=`RESET_PC`, IR=16'h0000.
  - Outputs: `dec_valid=0`, `imem_rd=1` (combinational in FETCH), `imem_addr=RESET_PC`.
  - Decoded fields all 0.
- Latency: FETCH entry to `dec_valid`=1 is 2 cycles. Unstalled throughput is 1 instruction per 3 cycles.
- `dec_valid` never drops without either acceptance or redirect. Fields do not change while `dec_valid=1`.
- `dec_valid` is 0 in the cycle after a redirect or acceptance.
- `pc_out` = pc register, so it equals the address of the instruction held in IR during VALID.

## Structure
- Shared package/include `cpu_defs`:
  - Opcode constants (OP_RTYPE, OP_ADDI, OP_SUBI, OP_CMPI, OP_BCOND, OP_ANDI, OP_ORI, OP_XORI, OP_MOVI, OP_LUI, OP_SHIFT).
  - State encodings S_FETCH/S_WAIT/S_VALID.
- One natural sub-module: `instr_field_decode`. It is combinational, maps IR to `opcode/rdest/opext/rsrc/imm8/imm_signed/is_imm`, and is reused by the disassembler bench.
- The top level holds the FSM, pc and IR.

## Test plan
- Reset, mem[0]=16'h5A85 (ADDI), `dec_ready=1` → `dec_valid` on cycle 2 with opcode=5, rdest=A, imm8=85, imm_signed=1, `pc_out`=0. Next fetch address is 1.
- mem[1]=16'h1A85 (ANDI) → imm_signed=0, is_imm=1. Through the sign extender this yields 16'h0085; the signed ADDI case yields 16'hFF85.
- Hold `dec_ready=0` for 5 cycles in VALID → all outputs stable, `imem_rd=0`, pc unchanged. Accept on cycle 6 → FETCH of pc+1.
- `redirect_valid` with `redirect_pc`=16'h0040 during WAIT → IR not loaded, next `imem_addr`=16'h0040, next `dec_valid` carries mem[0x40].
- VALID with `dec_ready=1` and redirect to 16'h0010 in the same cycle → next fetch is 16'h0010, not pc+1.
- Redirect to 16'hFFFF, accept → next fetch address is 16'h0000. Also assert `reset` during WAIT → outputs reach reset values immediately.
